// File: rtl/ledda_ctrl.sv
// ledda_ctrl -- configuration sequencer for the LED-driver (LEDDA) IP.
//
// Accepts a configuration request over a valid/ready handshake and programs
// the LED-driver register bus. The sequence is: stop the engine (DISABLE),
// write every register (WRITE, 3 cycles per register), then restart the
// engine with the requested run state (ENABLE). The controller is busy for
// 3N+2 cycles after each accepted request.
//
// Optional feature: define LEDDA_BREATHE_EN to add the breathe ports and the
// BCRR/BCFR register writes (N = 9 writes). Otherwise N = 7.
//
// Ports:
//   clk, reset                    system clock, synchronous active-high reset
//   cfg_valid / cfg_ready         request handshake (accept when both high)
//   cfg_enable                    engine run state after the update
//   cfg_prescale[9:0]             LED clock prescaler
//   cfg_on_time, cfg_off_time     blink periods
//   cfg_red/green/blue            PWM duty per channel
//   cfg_breathe_rise/fall         breathe ramps (LEDDA_BREATHE_EN only)
//   ledd_cs, ledd_clk, ledd_den   LED-driver register bus controls
//   ledd_exe, ledd_rst            engine enable and LED-driver reset
//   ledd_addr[3:0], ledd_dat[7:0] register address and write data
//   busy                          inverse of cfg_ready
`timescale 1ns/1ps

module ledda_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       cfg_enable,
    input  logic [9:0] cfg_prescale,
    input  logic [7:0] cfg_on_time,
    input  logic [7:0] cfg_off_time,
    input  logic [7:0] cfg_red,
    input  logic [7:0] cfg_green,
    input  logic [7:0] cfg_blue,
`ifdef LEDDA_BREATHE_EN
    input  logic [7:0] cfg_breathe_rise,
    input  logic [7:0] cfg_breathe_fall,
`endif
    output logic       ledd_cs,
    output logic       ledd_clk,
    output logic       ledd_den,
    output logic       ledd_exe,
    output logic       ledd_rst,
    output logic [3:0] ledd_addr,
    output logic [7:0] ledd_dat,
    output logic       busy
);

`ifdef LEDDA_BREATHE_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd6;
`endif

    typedef enum logic [1:0] {IDLE, DISABLE, WRITE, ENABLE} state_t;

    state_t     state, state_next;
    logic [3:0] idx, idx_next;
    logic [1:0] phase, phase_next;   // 0 = setup, 1 = strobe, 2 = hold
    logic       accept;

    logic       enable_q;
    logic [9:0] prescale_q;
    logic [7:0] on_q, off_q, red_q, green_q, blue_q;
`ifdef LEDDA_BREATHE_EN
    logic [7:0] rise_q, fall_q;
`endif

    // Register write table: returns {addr, data} for write number i.
    function automatic logic [11:0] reg_word(input logic [3:0] i);
        logic [11:0] w;
        w = 12'h000;
        case (i)
            4'd0: w = {4'h8, 1'b1, 5'b00000, prescale_q[9:8]};
            4'd1: w = {4'h9, prescale_q[7:0]};
            4'd2: w = {4'hA, on_q};
            4'd3: w = {4'hB, off_q};
`ifdef LEDDA_BREATHE_EN
            4'd4: w = {4'h5, rise_q};
            4'd5: w = {4'h6, fall_q};
            4'd6: w = {4'h1, red_q};
            4'd7: w = {4'h2, green_q};
            4'd8: w = {4'h3, blue_q};
`else
            4'd4: w = {4'h1, red_q};
            4'd5: w = {4'h2, green_q};
            4'd6: w = {4'h3, blue_q};
`endif
            default: w = 12'h000;
        endcase
        return w;
    endfunction

    // ledd_rst is a registered copy of reset, so cfg_ready stays low for the
    // whole time reset is held and rises on the first cycle after release.
    assign cfg_ready = (state == IDLE) && !ledd_rst;
    assign busy      = ~cfg_ready;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        phase_next = phase;
        accept     = 1'b0;
        ledd_cs    = 1'b0;
        ledd_den   = 1'b0;
        ledd_clk   = 1'b0;
        ledd_addr  = 4'h0;
        ledd_dat   = 8'h00;
        case (state)
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    accept     = 1'b1;
                    state_next = DISABLE;
                end
            end
            DISABLE: begin
                state_next = WRITE;
                idx_next   = 4'd0;
                phase_next = 2'd0;
            end
            WRITE: begin
                ledd_cs                = 1'b1;
                ledd_den               = 1'b1;
                ledd_clk               = (phase == 2'd1);
                {ledd_addr, ledd_dat}  = reg_word(idx);
                if (phase == 2'd2) begin
                    phase_next = 2'd0;
                    // The index stops at the last write: no second pass.
                    if (idx == LAST_IDX) state_next = ENABLE;
                    else                 idx_next   = idx + 4'd1;
                end else begin
                    phase_next = phase + 2'd1;
                end
            end
            ENABLE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 4'd0;
            phase      <= 2'd0;
            ledd_rst   <= 1'b1;
            ledd_exe   <= 1'b0;
            enable_q   <= 1'b0;
            prescale_q <= 10'd0;
            on_q       <= 8'h00;
            off_q      <= 8'h00;
            red_q      <= 8'h00;
            green_q    <= 8'h00;
            blue_q     <= 8'h00;
`ifdef LEDDA_BREATHE_EN
            rise_q     <= 8'h00;
            fall_q     <= 8'h00;
`endif
        end else begin
            ledd_rst <= 1'b0;
            state    <= state_next;
            idx      <= idx_next;
            phase    <= phase_next;
            if (accept) begin
                enable_q   <= cfg_enable;
                prescale_q <= cfg_prescale;
                on_q       <= cfg_on_time;
                off_q      <= cfg_off_time;
                red_q      <= cfg_red;
                green_q    <= cfg_green;
                blue_q     <= cfg_blue;
`ifdef LEDDA_BREATHE_EN
                rise_q     <= cfg_breathe_rise;
                fall_q     <= cfg_breathe_fall;
`endif
                // Engine stops for the DISABLE cycle and the whole update.
                ledd_exe   <= 1'b0;
            end
            // Engine run state becomes visible in the ENABLE cycle and holds.
            if (state == WRITE && state_next == ENABLE)
                ledd_exe <= enable_q;
        end
    end

endmodule

// File: tb/tb_ledda_ctrl.sv
// Self-checking bench for ledda_ctrl: table of configuration requests with
// expected engine state, a write scoreboard fed at request time and drained
// on every ledd_clk strobe, plus hand-written back-to-back and reset-abort
// sequences.
`timescale 1ns/1ps

module tb_ledda_ctrl;

`ifdef LEDDA_BREATHE_EN
    localparam int NW = 9;
`else
    localparam int NW = 7;
`endif

    logic       clk = 1'b0;
    logic       reset, cfg_valid, cfg_enable;
    logic [9:0] cfg_prescale;
    logic [7:0] cfg_on_time, cfg_off_time, cfg_red, cfg_green, cfg_blue;
    logic [7:0] cfg_breathe_rise, cfg_breathe_fall;
    logic       cfg_ready, busy;
    logic       ledd_cs, ledd_clk, ledd_den, ledd_exe, ledd_rst;
    logic [3:0] ledd_addr;
    logic [7:0] ledd_dat;

    ledda_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_enable   (cfg_enable),
        .cfg_prescale (cfg_prescale),
        .cfg_on_time  (cfg_on_time),
        .cfg_off_time (cfg_off_time),
        .cfg_red      (cfg_red),
        .cfg_green    (cfg_green),
        .cfg_blue     (cfg_blue),
`ifdef LEDDA_BREATHE_EN
        .cfg_breathe_rise (cfg_breathe_rise),
        .cfg_breathe_fall (cfg_breathe_fall),
`endif
        .ledd_cs      (ledd_cs),
        .ledd_clk     (ledd_clk),
        .ledd_den     (ledd_den),
        .ledd_exe     (ledd_exe),
        .ledd_rst     (ledd_rst),
        .ledd_addr    (ledd_addr),
        .ledd_dat     (ledd_dat),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] pre;
        logic [7:0] on_t, off_t, r, g, b, rise, fall;
        logic       en;
        logic       exp_exe;
    } req_t;

    req_t        vec[4];
    int          tests = 0;
    int          fails = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input req_t r);
        cfg_prescale     = r.pre;
        cfg_on_time      = r.on_t;
        cfg_off_time     = r.off_t;
        cfg_red          = r.r;
        cfg_green        = r.g;
        cfg_blue         = r.b;
        cfg_breathe_rise = r.rise;
        cfg_breathe_fall = r.fall;
        cfg_enable       = r.en;
    endtask

    // Expected register writes for one request, in bus order.
    task automatic push_writes(input req_t r);
        exp_q.push_back({4'h8, 1'b1, 5'b00000, r.pre[9:8]});
        exp_q.push_back({4'h9, r.pre[7:0]});
        exp_q.push_back({4'hA, r.on_t});
        exp_q.push_back({4'hB, r.off_t});
`ifdef LEDDA_BREATHE_EN
        exp_q.push_back({4'h5, r.rise});
        exp_q.push_back({4'h6, r.fall});
`endif
        exp_q.push_back({4'h1, r.r});
        exp_q.push_back({4'h2, r.g});
        exp_q.push_back({4'h3, r.b});
    endtask

    // Scoreboard: one write is consumed per ledd_clk strobe.
    always @(negedge clk) begin
        if (ledd_clk === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {ledd_addr, ledd_dat}, 12'h000);
            end else begin
                logic [11:0] w;
                w = exp_q.pop_front();
                chk("wr_addr", {28'd0, ledd_addr}, {28'd0, w[11:8]});
                chk("wr_dat", {24'd0, ledd_dat}, {24'd0, w[7:0]});
                chk("wr_cs_den", {30'd0, ledd_cs, ledd_den}, 32'd3);
            end
        end
    end

    // Called right after the accepting edge; returns at the first IDLE negedge.
    task automatic wait_done(output int cnt, output logic dis_exe);
        cnt = 0;
        @(negedge clk);
        dis_exe = ledd_exe;
        while (!cfg_ready && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_req(input req_t r);
        int   cnt;
        logic dx;
        @(negedge clk);
        set_inputs(r);
        cfg_valid = 1'b1;
        cnt = 0;
        while (!cfg_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("ready_before_req", {31'd0, cfg_ready}, 32'd1);
        push_writes(r);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        wait_done(cnt, dx);
        chk("busy_cycles", cnt, 3 * NW + 2);
        chk("exe_in_disable", {31'd0, dx}, 32'd0);
        chk("exe_final", {31'd0, ledd_exe}, {31'd0, r.exp_exe});
        chk("writes_left", exp_q.size(), 0);
        chk("idle_bus", {17'd0, ledd_cs, ledd_den, ledd_clk, ledd_addr, ledd_dat}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        logic dx;
        logic act;
        req_t ra, rb, rc;

        vec[0] = '{pre: 10'h155, on_t: 8'h20, off_t: 8'h40, r: 8'hFF, g: 8'h80, b: 8'h01,
                   rise: 8'h11, fall: 8'h22, en: 1'b1, exp_exe: 1'b1};
        vec[1] = '{pre: 10'h3FF, on_t: 8'h00, off_t: 8'hFF, r: 8'h00, g: 8'h55, b: 8'hAA,
                   rise: 8'hFE, fall: 8'h01, en: 1'b0, exp_exe: 1'b0};
        vec[2] = '{pre: 10'h200, on_t: 8'h01, off_t: 8'h02, r: 8'h03, g: 8'h04, b: 8'h05,
                   rise: 8'h06, fall: 8'h07, en: 1'b1, exp_exe: 1'b1};
        vec[3] = '{pre: 10'h0A3, on_t: 8'h7E, off_t: 8'h81, r: 8'hC3, g: 8'h3C, b: 8'h99,
                   rise: 8'h5A, fall: 8'hA5, en: 1'b1, exp_exe: 1'b1};

        reset     = 1'b1;
        cfg_valid = 1'b0;
        set_inputs(vec[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_ledd_rst", {31'd0, ledd_rst}, 32'd1);
        chk("rst_bus", {16'd0, ledd_cs, ledd_den, ledd_clk, ledd_exe, ledd_addr, ledd_dat}, 32'd0);

        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        chk("release_ready", {31'd0, cfg_ready}, 32'd1);
        chk("release_ledd_rst", {31'd0, ledd_rst}, 32'd0);

        // Table: vec[1] disables an engine left running by vec[0].
        for (int i = 0; i < 4; i++) run_req(vec[i]);

        // Back-to-back: valid held, inputs changed while busy.
        ra = vec[3];
        ra.en = 1'b0;
        ra.exp_exe = 1'b0;
        rb = vec[2];
        rb.pre = 10'h1C7;
        rb.g = 8'hE1;
        rc = vec[1];
        @(negedge clk);
        set_inputs(ra);
        cfg_valid = 1'b1;
        chk("b2b_ready_a", {31'd0, cfg_ready}, 32'd1);
        push_writes(ra);
        @(posedge clk);
        #1 set_inputs(rb);
        wait_done(cnt, dx);
        chk("b2b_cycles_a", cnt, 3 * NW + 2);
        chk("b2b_exe_a", {31'd0, ledd_exe}, 32'd0);
        chk("b2b_ready_first_idle", {31'd0, cfg_ready}, 32'd1);
        push_writes(rb);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        set_inputs(rc);
        wait_done(cnt, dx);
        chk("b2b_cycles_b", cnt, 3 * NW + 2);
        chk("b2b_exe_b", {31'd0, ledd_exe}, 32'd1);
        chk("b2b_writes_left", exp_q.size(), 0);

        // Reset during the 4th write (OFR).
        @(negedge clk);
        set_inputs(vec[0]);
        cfg_valid = 1'b1;
        push_writes(vec[0]);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (ledd_addr !== 4'hB && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("reach_4th_write", {28'd0, ledd_addr}, 32'hB);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_bus", {16'd0, ledd_cs, ledd_den, ledd_clk, ledd_exe, ledd_addr, ledd_dat}, 32'd0);
        chk("abort_ledd_rst", {31'd0, ledd_rst}, 32'd1);
        chk("abort_ready", {31'd0, cfg_ready}, 32'd0);
        exp_q.delete();
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_release_ready", {31'd0, cfg_ready}, 32'd1);
        act = 1'b0;
        repeat (5) begin
            @(negedge clk);
            act = act | ledd_cs | ledd_den | ledd_clk | ledd_exe | (|ledd_addr) | (|ledd_dat);
        end
        chk("abort_quiet", {31'd0, act}, 32'd0);

        // Recovery after abort.
        run_req(vec[3]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ledda_ctrl.md
LEDDA_CTRL -- requirements
Module: ledda_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port cfg_valid, input, 1 bit: a configuration request is present.
REQ-004 SHALL have port cfg_ready, output, 1 bit: the controller is idle and accepts a request.
REQ-005 SHALL have port cfg_enable, input, 1 bit: LED engine run state after the update.
REQ-006 SHALL have port cfg_prescale, input, 10 bits: LED clock prescaler.
REQ-007 SHALL have ports cfg_on_time and cfg_off_time, inputs, 8 bits each: blink on and off periods.
REQ-008 SHALL have ports cfg_red, cfg_green and cfg_blue, inputs, 8 bits each: PWM duty per channel.
REQ-009 SHALL have ports cfg_breathe_rise and cfg_breathe_fall, inputs, 8 bits each; present only with LEDDA_BREATHE_EN.
REQ-010 SHALL have ports ledd_cs, ledd_clk, ledd_den, ledd_exe and ledd_rst, outputs, 1 bit each, driving the LED-driver IP register bus.
REQ-011 SHALL have ports ledd_addr, output, 4 bits, and ledd_dat, output, 8 bits: register address and write data.
REQ-012 SHALL have port busy, output, 1 bit, equal to the inverse of cfg_ready.

Function
REQ-013 Handshake: a request SHALL be accepted on the cycle cfg_valid and cfg_ready are both 1.
- All cfg_* inputs SHALL be latched on that cycle.
- Inputs SHALL be ignored at all other times.
REQ-014 States SHALL be IDLE -> DISABLE -> WRITE -> ENABLE -> IDLE.
- IDLE: cfg_ready=1.
- Any other state: cfg_ready=0.
REQ-015 DISABLE SHALL last 1 cycle and drive ledd_exe=0.
REQ-016 WRITE SHALL issue each register write in 3 cycles, with ledd_cs=1, ledd_den=1, and ledd_addr/ledd_dat stable for all three:
- SETUP: ledd_clk=0.
- STROBE: ledd_clk=1.
- HOLD: ledd_clk=0.
REQ-017 Write order and content SHALL be:
- 0x8 CR0 = {1,0,0,0,0,0,prescale[9:8]}
- 0x9 BR = prescale[7:0]
- 0xA ONR = on_time
- 0xB OFR = off_time
- [0x5 BCRR = breathe_rise, 0x6 BCFR = breathe_fall]
- 0x1 PWRR = red
- 0x2 PWRG = green
- 0x3 PWRB = blue
REQ-018 Between writes, ledd_cs and ledd_den SHALL stay 1; on leaving WRITE, both SHALL go to 0 and ledd_addr/ledd_dat to 0.
REQ-019 ENABLE SHALL last 1 cycle and set ledd_exe to the latched cfg_enable; ledd_exe SHALL hold that value until the next DISABLE.
REQ-020 Latency: cfg_ready SHALL be 0 for exactly 3N+2 cycles after the accept cycle, where N is the write count: 29 cycles with the macro, 23 without.
REQ-021 cfg_valid held high while busy SHALL have no effect; a back-to-back request SHALL be accepted on the first IDLE cycle.
REQ-022 The write index SHALL never exceed N-1; there SHALL be no wrap-around into a second pass.

Reset
REQ-023 In reset, outputs SHALL be:
- cfg_ready=0, busy=1
- ledd_cs=0, ledd_clk=0, ledd_den=0, ledd_exe=0
- ledd_addr=0, ledd_dat=0
- ledd_rst=1
- state=IDLE
REQ-024 In the first cycle after reset deasserts, ledd_rst SHALL be 0 and cfg_ready SHALL be 1.
REQ-025 Reset asserted mid-sequence SHALL abort the transfer that cycle; no further bus activity SHALL occur and no partial state SHALL be retained.

Configuration
REQ-026 LEDDA_BREATHE_EN defined: the breathe ports SHALL exist and the BCRR/BCFR writes SHALL be issued (N=9).
REQ-027 LEDDA_BREATHE_EN undefined: the breathe ports SHALL be absent, those writes skipped (N=7), and the remaining order unchanged.

Verification
REQ-028 Reset, release, request prescale=0x155, on=0x20, off=0x40, r=0xFF, g=0x80, b=0x01, enable=1 -> writes:
- 0x8/0x81, 0x9/0x55, 0xA/0x20, 0xB/0x40, 0x1/0xFF, 0x2/0x80, 0x3/0x01, with breathe writes inserted when enabled.
- One ledd_clk pulse per write.
- ledd_exe=1 at the end.
REQ-029 Count cfg_ready low cycles after accept -> 29 with macro, 23 without.
REQ-030 Request with enable=0 while ledd_exe=1 -> ledd_exe falls in DISABLE and stays 0 after ENABLE.
REQ-031 Assert reset during the 4th write -> next cycle all bus outputs are 0, ledd_rst=1; after release, cfg_ready=1.
REQ-032 Change cfg_* and hold cfg_valid during a sequence -> written data equals the values latched at accept, and a second sequence starts on the first IDLE cycle.
